// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles the write-back request side and the register-file
// write-back port of wb_arbiter.
//
// Valid/ready semantics: req_i[k] is unit k's "valid". gnt_o[k] is the
// same-cycle "ready". A transfer happens on the clk edge that ends a cycle
// with req_i[k] && gnt_o[k]. Until then, the unit holds req_i[k] and its
// req_r_i/req_data_i slices stable. It may drop or replace the request in
// the following cycle.
//
// Signals:
//   req_i      [N_REQ]        write-back request per unit
//   urgent_i   [N_REQ]        urgent qualifier (only meaningful with req_i)
//   req_r_i    [N_REQ*W_RD]   destination register, unit k at [k*W_RD +: W_RD]
//   req_data_i [N_REQ*W_OPR]  result data, unit k at [k*W_OPR +: W_OPR]
//   gnt_o      [N_REQ]        one-hot grant, combinational
//   wb_o                      registered write-back strobe
//   wb_r_o     [W_RD]         registered write-back register number
//   result_o   [W_OPR]        registered write-back data
//   wb_cnt_o   [16]           saturating count of write-backs
//   dbg_ptr_o  [W_PTR]        current round-robin pointer (debug visibility)
// Modports: slave = the arbiter, master = the units / register file side.
interface wb_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W_RD  = 4,
  parameter int W_OPR = 32,
  parameter int W_PTR = 2
);
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ-1:0]       urgent_i;
  logic [N_REQ*W_RD-1:0]  req_r_i;
  logic [N_REQ*W_OPR-1:0] req_data_i;
  logic [N_REQ-1:0]       gnt_o;
  logic                   wb_o;
  logic [W_RD-1:0]        wb_r_o;
  logic [W_OPR-1:0]       result_o;
  logic [15:0]            wb_cnt_o;
  logic [W_PTR-1:0]       dbg_ptr_o;

  modport slave (
    input  req_i, urgent_i, req_r_i, req_data_i,
    output gnt_o, wb_o, wb_r_o, result_o, wb_cnt_o, dbg_ptr_o
  );

  modport master (
    output req_i, urgent_i, req_r_i, req_data_i,
    input  gnt_o, wb_o, wb_r_o, result_o, wb_cnt_o, dbg_ptr_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the single register-file write-back port among N_REQ
// execution units that complete out of order.
//
// Each cycle, at most one request is granted, and the grant is combinational.
// Urgent requesters form the eligible set when any exist; otherwise all
// requesters do. Within that set, round-robin selection starts at the
// pointer. The granted register/data is registered onto the write-back port
// one cycle later.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  wb_arbiter_if.slave (requests in; grant and write-back port out)
module wb_arbiter #(
  parameter int N_REQ = 4,
  parameter int W_RD  = 4,
  parameter int W_OPR = 32,
  parameter int W_PTR = 2
) (
  input  logic            clk,
  input  logic            rst,
  wb_arbiter_if.slave     bus
);

  logic [W_PTR-1:0] ptr_q, ptr_d;
  logic             wb_q;
  logic [W_RD-1:0]  wb_r_q, wb_r_d;
  logic [W_OPR-1:0] result_q, result_d;
  logic [15:0]      wb_cnt_q, wb_cnt_d;

  logic [N_REQ-1:0] urg_req;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic             found;
  logic             grant;
  logic [W_PTR-1:0] ptr_nxt;
  logic [W_RD-1:0]  sel_r;
  logic [W_OPR-1:0] sel_data;

  // Urgent requesters pre-empt the rotation entirely when any are present.
  assign urg_req = bus.req_i & bus.urgent_i;
  assign elig    = (urg_req != '0) ? urg_req : bus.req_i;

  // Round-robin scan as two passes, so no dynamic index is needed. The
  // first pass covers units at or above the pointer, and the second covers
  // units below it. The first hit wins, and its successor becomes the next
  // pointer.
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    ptr_nxt  = ptr_q;
    sel_r    = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && elig[k] && (k >= int'(ptr_q))) begin
        found    = 1'b1;
        gnt[k]   = 1'b1;
        ptr_nxt  = W_PTR'((k + 1) % N_REQ);
        sel_r    = bus.req_r_i[k*W_RD +: W_RD];
        sel_data = bus.req_data_i[k*W_OPR +: W_OPR];
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && elig[k] && (k < int'(ptr_q))) begin
        found    = 1'b1;
        gnt[k]   = 1'b1;
        ptr_nxt  = W_PTR'((k + 1) % N_REQ);
        sel_r    = bus.req_r_i[k*W_RD +: W_RD];
        sel_data = bus.req_data_i[k*W_OPR +: W_OPR];
      end
    end
  end

  // A reset cycle never grants, so a unit cannot believe a request was
  // consumed when the edge actually resets the arbiter.
  assign grant     = found && !rst;
  assign bus.gnt_o = rst ? '0 : gnt;

  always_comb begin
    ptr_d    = ptr_q;
    wb_r_d   = wb_r_q;
    result_d = result_q;
    wb_cnt_d = wb_cnt_q;
    if (grant) begin
      ptr_d    = ptr_nxt;
      wb_r_d   = sel_r;
      result_d = sel_data;
      if (wb_cnt_q != 16'hFFFF) wb_cnt_d = wb_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      wb_q     <= 1'b0;
      wb_r_q   <= '0;
      result_q <= '0;
      wb_cnt_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wb_q     <= grant;
      wb_r_q   <= wb_r_d;
      result_q <= result_d;
      wb_cnt_q <= wb_cnt_d;
    end
  end

  assign bus.wb_o      = wb_q;
  assign bus.wb_r_o    = wb_r_q;
  assign bus.result_o  = result_q;
  assign bus.wb_cnt_o  = wb_cnt_q;
  assign bus.dbg_ptr_o = ptr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed test of wb_arbiter with hand-computed expectations.
// Inputs change 1 ns after a rising edge. The combinational grant is checked
// 1 ns after that. Registered outputs are checked 1 ns after the next edge.
module tb_wb_arbiter;

  localparam int N_REQ = 4;
  localparam int W_RD  = 4;
  localparam int W_OPR = 32;
  localparam int W_PTR = 2;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.N_REQ(N_REQ), .W_RD(W_RD), .W_OPR(W_OPR), .W_PTR(W_PTR)) bus ();

  wb_arbiter #(.N_REQ(N_REQ), .W_RD(W_RD), .W_OPR(W_OPR), .W_PTR(W_PTR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Driver tasks
  task automatic set_unit(input int k, input logic [W_RD-1:0] r, input logic [W_OPR-1:0] d);
    bus.req_r_i[k*W_RD +: W_RD]     = r;
    bus.req_data_i[k*W_OPR +: W_OPR] = d;
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [N_REQ-1:0] rr_exp [5];

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    rst            = 1'b1;
    bus.req_i      = '0;
    bus.urgent_i   = '0;
    bus.req_r_i    = '0;
    bus.req_data_i = '0;

    // Reset: a pending request must not be granted.
    tick();
    bus.req_i = 4'b0001;
    #1;
    chk("rst_gnt", 64'(bus.gnt_o), 64'h0);
    tick();
    chk("rst_wb", 64'(bus.wb_o), 64'h0);
    chk("rst_wb_r", 64'(bus.wb_r_o), 64'h0);
    chk("rst_result", 64'(bus.result_o), 64'h0);
    chk("rst_cnt", 64'(bus.wb_cnt_o), 64'h0);
    chk("rst_ptr", 64'(bus.dbg_ptr_o), 64'h0);
    bus.req_i = '0;
    rst = 1'b0;
    tick();
    chk("idle_wb", 64'(bus.wb_o), 64'h0);

    // Single request on unit 2.
    set_unit(2, 4'd5, 32'hDEADBEEF);
    bus.req_i = 4'b0100;
    #1;
    chk("single_gnt", 64'(bus.gnt_o), 64'h4);
    tick();
    bus.req_i = '0;
    chk("single_wb", 64'(bus.wb_o), 64'h1);
    chk("single_wb_r", 64'(bus.wb_r_o), 64'h5);
    chk("single_result", 64'(bus.result_o), 64'hDEADBEEF);
    chk("single_ptr", 64'(bus.dbg_ptr_o), 64'h3);
    chk("single_cnt", 64'(bus.wb_cnt_o), 64'h1);

    // Unit 3 alone brings the pointer back to 0, and the grant wraps.
    set_unit(3, 4'd11, 32'd103);
    bus.req_i = 4'b1000;
    #1;
    chk("wrap_gnt", 64'(bus.gnt_o), 64'h8);
    tick();
    chk("wrap_ptr", 64'(bus.dbg_ptr_o), 64'h0);

    // Round robin: all four hold requests.
    for (int k = 0; k < N_REQ; k++) set_unit(k, 4'(k + 8), 32'(100 + k));
    bus.req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_gnt%0d", i), 64'(bus.gnt_o), 64'(rr_exp[i]));
      tick();
      chk($sformatf("rr_wb%0d", i), 64'(bus.wb_o), 64'h1);
      chk($sformatf("rr_wb_r%0d", i), 64'(bus.wb_r_o), 64'((i % 4) + 8));
    end
    chk("rr_ptr", 64'(bus.dbg_ptr_o), 64'h1);
    chk("rr_cnt", 64'(bus.wb_cnt_o), 64'd7);

    // Return the pointer to 0 via unit 3.
    bus.req_i = 4'b1000;
    tick();
    chk("pre_urg_ptr", 64'(bus.dbg_ptr_o), 64'h0);

    // Urgent override.
    bus.req_i    = 4'b1111;
    bus.urgent_i = 4'b1000;
    #1;
    chk("urg_gnt", 64'(bus.gnt_o), 64'h8);
    tick();
    chk("urg_ptr", 64'(bus.dbg_ptr_o), 64'h0);
    chk("urg_result", 64'(bus.result_o), 64'd103);
    bus.urgent_i = '0;
    #1;
    chk("post_urg_gnt", 64'(bus.gnt_o), 64'h1);
    tick();
    chk("post_urg_result", 64'(bus.result_o), 64'd100);
    chk("post_urg_ptr", 64'(bus.dbg_ptr_o), 64'h1);
    chk("post_urg_cnt", 64'(bus.wb_cnt_o), 64'd10);
    // Urgent bit without a matching request is ignored.
    bus.req_i    = 4'b0100;
    bus.urgent_i = 4'b0001;
    #1;
    chk("urg_noreq_gnt", 64'(bus.gnt_o), 64'h4);
    bus.req_i    = 4'b1000;
    bus.urgent_i = '0;
    tick();
    chk("pre_same_ptr", 64'(bus.dbg_ptr_o), 64'h0);

    // Same destination from units 1 and 3.
    set_unit(1, 4'd7, 32'd1);
    set_unit(3, 4'd7, 32'd2);
    bus.req_i = 4'b1010;
    #1;
    chk("same_gnt1", 64'(bus.gnt_o), 64'h2);
    tick();
    chk("same_wb_r1", 64'(bus.wb_r_o), 64'h7);
    chk("same_result1", 64'(bus.result_o), 64'h1);
    bus.req_i = 4'b1000;
    #1;
    chk("same_gnt2", 64'(bus.gnt_o), 64'h8);
    tick();
    chk("same_wb_r2", 64'(bus.wb_r_o), 64'h7);
    chk("same_result2", 64'(bus.result_o), 64'h2);
    chk("same_cnt", 64'(bus.wb_cnt_o), 64'd13);

    // Idle and hold.
    set_unit(0, 4'd1, 32'hA5);
    bus.req_i = 4'b0001;
    #1;
    chk("hold_gnt", 64'(bus.gnt_o), 64'h1);
    tick();
    bus.req_i = '0;
    chk("hold_wb1", 64'(bus.wb_o), 64'h1);
    chk("hold_result1", 64'(bus.result_o), 64'hA5);
    #1;
    chk("hold_nogrant", 64'(bus.gnt_o), 64'h0);
    tick();
    chk("hold_wb0", 64'(bus.wb_o), 64'h0);
    chk("hold_result", 64'(bus.result_o), 64'hA5);
    chk("hold_wb_r", 64'(bus.wb_r_o), 64'h1);
    chk("hold_ptr", 64'(bus.dbg_ptr_o), 64'h1);
    chk("hold_cnt", 64'(bus.wb_cnt_o), 64'd14);

    // Reset mid-stream with ptr=1 and two pending requests.
    bus.req_i = 4'b0011;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 64'(bus.gnt_o), 64'h0);
    tick();
    rst = 1'b0;
    chk("mid_rst_wb", 64'(bus.wb_o), 64'h0);
    chk("mid_rst_cnt", 64'(bus.wb_cnt_o), 64'h0);
    chk("mid_rst_ptr", 64'(bus.dbg_ptr_o), 64'h0);
    #1;
    chk("mid_rst_gnt_after", 64'(bus.gnt_o), 64'h1);
    tick();
    bus.req_i = '0;
    chk("mid_rst_wb_after", 64'(bus.wb_o), 64'h1);
    chk("mid_rst_result", 64'(bus.result_o), 64'hA5);
    chk("mid_rst_cnt_after", 64'(bus.wb_cnt_o), 64'h1);
    chk("mid_rst_ptr_after", 64'(bus.dbg_ptr_o), 64'h1);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
